// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor computing A - B - bin.
// Operands are consumed LSB first, one bit per clock, through a single
// borrow flip-flop. A start/busy/done handshake frames each operation.
// The difference is delivered both as a streamed bit (d_ser/d_valid) and
// as a parallel word (diff/bo) that is held until the next accepted start.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             d_ser,
    output logic             d_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic            br;
    logic [CW-1:0]   count;

    // One-bit full-subtractor difference: a - b - c (mod 2).
    function automatic logic sub_bit(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Borrow out of the one-bit subtraction a - b - c.
    function automatic logic sub_borrow(input logic a, input logic b, input logic c);
        return (~a & b) | (~(a ^ b) & c);
    endfunction

    logic            d_cur;
    logic            br_next;
    logic [WIDTH-1:0] res_next;
    logic            last_bit;

    // Current bit slice: difference and borrow of the operand LSBs.
    always_comb begin
        d_cur    = sub_bit(sa[0], sb[0], br);
        br_next  = sub_borrow(sa[0], sb[0], br);
        res_next = {d_cur, res[WIDTH-1:1]};
        last_bit = (count == LAST);
    end

    // Handshake FSM and bit-serial datapath; every output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bo      <= 1'b0;
            d_ser   <= 1'b0;
            d_valid <= 1'b0;
            sa      <= '0;
            sb      <= '0;
            res     <= '0;
            br      <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    d_valid <= 1'b0;
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        br    <= bin;
                        res   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    // start is deliberately ignored here; the in-flight
                    // operands live only in sa/sb/br.
                    d_ser   <= d_cur;
                    d_valid <= 1'b1;
                    res     <= res_next;
                    sa      <= sa >> 1;
                    sb      <= sb >> 1;
                    br      <= br_next;
                    count   <= count + CW'(1);
                    if (last_bit) begin
                        // The final serial bit is presented in the same
                        // cycle as done, so the stream carries all WIDTH bits.
                        diff  <= res_next;
                        bo    <= br_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    d_valid <= 1'b0;
                    if (start) begin
                        // Back-to-back acceptance: busy stays high, no bubble.
                        sa    <= A;
                        sb    <= B;
                        br    <= bin;
                        res   <= '0;
                        count <= '0;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    d_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and randomised checks of serial_sub at
// WIDTH = 8, 2 and 32. Expected results come from an arithmetic model
// and travel through a scoreboard queue to the done pulse.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        bin_in;
    logic [2:0]  st;

    logic        busy8, done8, bo8, ds8, dv8;
    logic [7:0]  diff8;
    logic        busy2, done2, bo2, ds2, dv2;
    logic [1:0]  diff2;
    logic        busy32, done32, bo32, ds32, dv32;
    logic [31:0] diff32;

    // Packed view per DUT: {busy, done, bo, d_ser, d_valid, diff[31:0]}
    logic [36:0] ob [3];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] diff;
        logic        bo;
    } res_t;

    res_t        sbq[$];
    logic [31:0] last_diff;
    logic        last_bo;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .A(a_in[7:0]), .B(b_in[7:0]), .bin(bin_in),
        .busy(busy8), .done(done8), .diff(diff8), .bo(bo8),
        .d_ser(ds8), .d_valid(dv8)
    );

    serial_sub #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .A(a_in[1:0]), .B(b_in[1:0]), .bin(bin_in),
        .busy(busy2), .done(done2), .diff(diff2), .bo(bo2),
        .d_ser(ds2), .d_valid(dv2)
    );

    serial_sub #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(st[2]),
        .A(a_in), .B(b_in), .bin(bin_in),
        .busy(busy32), .done(done32), .diff(diff32), .bo(bo32),
        .d_ser(ds32), .d_valid(dv32)
    );

    assign ob[0] = {busy8, done8, bo8, ds8, dv8, 24'd0, diff8};
    assign ob[1] = {busy2, done2, bo2, ds2, dv2, 30'd0, diff2};
    assign ob[2] = {busy32, done32, bo32, ds32, dv32, diff32};

    function automatic int idx(input int w);
        if (w == 8) return 0;
        if (w == 2) return 1;
        return 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on the DUT of width w. inj >= 0 pulses start with new
    // operands during RUN; keep leaves start high for back-to-back runs.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input int inj, input bit keep);
        logic [31:0] m;
        logic [32:0] full;
        res_t        e;
        res_t        p;
        logic [36:0] o;
        int          k;
        int          nval;
        int          cyc;
        bit          got;
        k    = idx(w);
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & m} - {1'b0, b & m} - {32'd0, ci};
        e.diff = full[31:0] & m;
        e.bo   = full[w];
        sbq.push_back(e);

        a_in   = a;
        b_in   = b;
        bin_in = ci;
        st[k]  = 1'b1;
        @(posedge clk); #1;
        if (!keep) begin
            st[k]  = 1'b0;
            a_in   = $urandom;
            b_in   = $urandom;
            bin_in = 1'($urandom_range(0, 1));
        end
        o = ob[k];
        chk("busy_after_accept", 64'(o[36]), 64'(1));
        chk("dvalid_after_accept", 64'(o[32]), 64'(0));

        nval = 0;
        cyc  = 0;
        got  = 1'b0;
        while (!got && cyc < w + 4) begin
            if (cyc == inj) begin
                st[k] = 1'b1;
                a_in  = 32'h0;
                b_in  = 32'hFF;
            end
            @(posedge clk); #1;
            cyc++;
            if (inj >= 0 && cyc == inj + 1) st[k] = 1'b0;
            o = ob[k];
            if (o[32]) begin
                if (nval < 32) chk("d_ser_bit", 64'(o[33]), 64'(e.diff[nval]));
                nval++;
            end
            if (o[35]) begin
                got = 1'b1;
                if (sbq.size() > 0) begin
                    p = sbq.pop_front();
                    chk("diff", 64'(o[31:0]), 64'(p.diff));
                    chk("bo", 64'(o[34]), 64'(p.bo));
                end else begin
                    chk("scoreboard_underflow", 64'(1), 64'(0));
                end
                chk("serial_bit_count", 64'(nval), 64'(w));
                chk("done_latency", 64'(cyc), 64'(w));
                chk("busy_at_done", 64'(o[36]), 64'(1));
                last_diff = o[31:0];
                last_bo   = o[34];
            end else begin
                chk("busy_during_run", 64'(o[36]), 64'(1));
            end
        end
        if (!got) chk("done_timeout", 64'(0), 64'(1));

        if (!keep) begin
            @(posedge clk); #1;
            o = ob[k];
            chk("done_single_pulse", 64'(o[35]), 64'(0));
            chk("busy_back_idle", 64'(o[36]), 64'(0));
            chk("dvalid_idle", 64'(o[32]), 64'(0));
            chk("diff_held", 64'(o[31:0]), 64'(last_diff));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        st     = 3'b000;
        a_in   = '0;
        b_in   = '0;
        bin_in = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) chk("reset_outputs", 64'(ob[i]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) chk("idle_after_reset", 64'(ob[i]), 64'(0));

        // Basic operation, stream checked bit by bit inside run_op
        run_op(8, 32'h5A, 32'h3C, 1'b0, -1, 1'b0);
        chk("5a_3c_diff", 64'(last_diff), 64'h1E);
        chk("5a_3c_bo", 64'(last_bo), 64'(0));

        // Wrap-around corners
        run_op(8, 32'h00, 32'h01, 1'b0, -1, 1'b0);
        chk("0_minus_1_diff", 64'(last_diff), 64'hFF);
        chk("0_minus_1_bo", 64'(last_bo), 64'(1));
        run_op(8, 32'h10, 32'h10, 1'b1, -1, 1'b0);
        chk("eq_bin_diff", 64'(last_diff), 64'hFF);
        chk("eq_bin_bo", 64'(last_bo), 64'(1));
        run_op(8, 32'hFF, 32'h00, 1'b1, -1, 1'b0);
        chk("ff_bin_diff", 64'(last_diff), 64'hFE);
        chk("ff_bin_bo", 64'(last_bo), 64'(0));

        // start pulsed on the third RUN cycle is ignored
        run_op(8, 32'h5A, 32'h3C, 1'b0, 2, 1'b0);
        chk("ignored_start_diff", 64'(last_diff), 64'h1E);
        chk("ignored_start_bo", 64'(last_bo), 64'(0));

        // start held high: back-to-back operations every WIDTH+1 cycles
        for (int i = 0; i < 3; i++) begin
            run_op(8, 32'h80, 32'h01, 1'b0, -1, 1'b1);
            chk("b2b_diff", 64'(last_diff), 64'h7F);
            chk("b2b_bo", 64'(last_bo), 64'(0));
        end
        run_op(8, 32'h80, 32'h01, 1'b0, -1, 1'b0);
        chk("b2b_last_diff", 64'(last_diff), 64'h7F);

        // Asynchronous reset between edges aborts an operation
        a_in   = 32'h5A;
        b_in   = 32'h3C;
        bin_in = 1'b0;
        st[0]  = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_immediate", 64'(ob[0]), 64'(0));
        repeat (2) begin
            @(posedge clk); #1;
            chk("held_in_reset", 64'(ob[0]), 64'(0));
        end
        #3;
        rst_n = 1'b1;
        repeat (11) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", 64'(ob[0][36:35]), 64'(0));
        end
        run_op(8, 32'h5A, 32'h3C, 1'b0, -1, 1'b0);
        chk("after_reset_diff", 64'(last_diff), 64'h1E);
        chk("after_reset_bo", 64'(last_bo), 64'(0));

        // Randomised sweeps against the arithmetic model
        for (int i = 0; i < 1000; i++)
            run_op(8, $urandom, $urandom, 1'($urandom_range(0, 1)), -1, 1'b0);
        for (int i = 0; i < 100; i++)
            run_op(2, $urandom, $urandom, 1'($urandom_range(0, 1)), -1, 1'b0);
        run_op(32, 32'h0, 32'hFFFF_FFFF, 1'b1, -1, 1'b0);
        chk("w32_wrap_diff", 64'(last_diff), 64'h0000_0000);
        chk("w32_wrap_bo", 64'(last_bo), 64'(1));
        for (int i = 0; i < 60; i++)
            run_op(32, $urandom, $urandom, 1'($urandom_range(0, 1)), -1, 1'b0);

        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
